ama_riscv_csr_hpm: RTL and testbench
====================================

Name: ama_riscv_csr_hpm

Overview:
Parametrised machine counter/performance-monitor CSR unit for the core's EXE stage. Provides mcycle, minstret, NUM_CNT programmable mhpmcounters with mhpmevent selectors, and mcountinhibit. Exposes a single-port CSR access interface with assign/set/clear semantics and per-counter overflow pulses. Replaces the core's fixed-function inline counters.

Parameters:
NUM_CNT, 4, number of mhpmcounterN/mhpmeventN pairs, N = 3..3+NUM_CNT-1; legal range 0..29
CNT_WIDTH, 64, implemented counter width, legal range 33..64; bits above CNT_WIDTH read 0
NUM_EVT, 8, width of event input vector; selector value k (1..NUM_EVT) selects evt[k-1]
EVT_SEL_W, $clog2(NUM_EVT+1), mhpmevent stored width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset
csr_en  in  1  CSR access valid this cycle
csr_we  in  1  CSR write (qualified by csr_en)
csr_addr  in  12  CSR address
csr_op  in  2  0 assign, 1 set bits, 2 clear bits, 3 no write
csr_wdata  in  32  write operand (rs1 value or zero-extended imm)
csr_rdata  out  32  read data, combinational
csr_hit  out  1  csr_addr is implemented here, combinational
inst_retire  in  1  one instruction retires this cycle
evt  in  NUM_EVT  event strobes, each bit = one occurrence this cycle
ovf  out  NUM_CNT  per-hpm-counter wrap pulse, registered

Behaviour:
- Reset (rst, synchronous, active-high; clock clk): all counters, mhpmevent, mcountinhibit, ovf = 0.
- Address map: mcycle 0xB00/0xB80(h), minstret 0xB02/0xB82(h), mhpmcounterN 0xB00+N / 0xB80+N, mhpmeventN 0x320+N, mcountinhibit 0x320.
- csr_hit = csr_en && address in map for configured NUM_CNT; else csr_rdata = 0, writes ignored.
- Read: csr_rdata = current register value (low 32 or high CNT_WIDTH-32 bits zero-extended); same-cycle, no latency.
- Write data: assign = wdata; set = cur | wdata; clear = cur & ~wdata; cur = pre-write value. Write occurs when csr_en && csr_we && csr_hit && csr_op != 3; visible on csr_rdata next cycle.
- Writing a low half leaves high half unchanged and vice versa. High-half writes keep only CNT_WIDTH-32 LSBs.
- mhpmevent stores low EVT_SEL_W bits; value 0 or > NUM_EVT counts nothing.
- mcountinhibit: bit0 CY, bit2 IR, bit 3+i HPM i; bit1 and unimplemented bits read 0, not writable.
- Increment per cycle: mcycle +1 unless inhibited; minstret +inst_retire unless inhibited; hpm i +1 when selected evt bit = 1 and not inhibited.
- Write vs increment same cycle, same counter (either half): write wins, no increment that cycle for full counter.
- Wrap: counter at 2^CNT_WIDTH-1 incremented becomes 0; ovf[i] high exactly one cycle after the wrapping edge. Write-to-zero does not raise ovf. mcycle/minstret wrap silently.
- Inhibit change takes effect in the cycle after the write; in the writing cycle the old inhibit value governs increments.
- rst mid-count: all state cleared next edge, ovf pending pulse dropped.

Test Plan:
- Reset, then read 0xB00 at cycle 10 after reset deassert -> rdata = 10 (with counter counting from first post-reset edge, check monotone +1/cycle); read 0xC00 -> csr_hit=0, rdata=0.
- Write mhpmevent3=2, pulse evt[1] 5 cycles, evt[0] 3 cycles -> mhpmcounter3 = 5; mhpmevent3=0x1F (NUM_EVT=8) -> no counting.
- Write mcountinhibit=0x5 -> mcycle and minstret frozen with inst_retire=1 for 20 cycles; clear bits (csr_op=2, wdata=0x5) -> counting resumes next cycle.
- Load mhpmcounter3 high=0xFFFFFFFF, low=0xFFFFFFFE, event held high -> 0xFFFFFFFF_FFFFFFFF, then 0; ovf[0] single pulse following wrap edge.
- csr assign 0x100 to minstret low with inst_retire=1 same cycle -> reads 0x100 next cycle, 0x101 the cycle after; high half unchanged.
- Set op 0xF0 on mhpmcounter4 low = 0x0F -> 0xFF; assert rst while counting -> all reads 0, ovf 0 next cycle.

Source files
------------

// File: rtl/ama_riscv_csr_hpm.sv
// Machine counter / hardware performance-monitor CSR block: mcycle, minstret,
// NUM_CNT event-selected mhpmcounters, their mhpmevent selectors and mcountinhibit.
module ama_riscv_csr_hpm #(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 64,
  parameter int NUM_EVT   = 8,
  parameter int EVT_SEL_W = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_en,
  input  logic               csr_we,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_hit,
  input  logic               inst_retire,
  input  logic [NUM_EVT-1:0] evt,
  output logic [NUM_CNT-1:0] ovf
);

  // Counter slot 0 is mcycle, slot 1 minstret, slot 2+i is mhpmcounter(3+i).
  localparam int NTOT = NUM_CNT + 2;
  localparam int HI_W = CNT_WIDTH - 32;
  localparam logic [31:0] INH_MASK = 32'h5 | 32'(((64'd1 << NUM_CNT) - 64'd1) << 3);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_cnt [NTOT];
  logic [EVT_SEL_W-1:0] r_evt [NUM_CNT];
  logic [31:0]          r_inh;
  logic [NUM_CNT-1:0]   r_ovf;

  logic               w_map;
  logic               w_inh_sel;
  logic               w_wr;
  logic [NTOT-1:0]    w_lo_sel;
  logic [NTOT-1:0]    w_hi_sel;
  logic [NTOT-1:0]    w_inc;
  logic [NUM_CNT-1:0] w_evt_sel;
  logic [NUM_CNT-1:0] w_wrap;
  logic [31:0]        w_cur;
  logic [31:0]        w_wval;

  function automatic logic [11:0] cnt_addr(input int k, input logic hi);
    logic [11:0] a;
    a = (k == 0) ? 12'hB00 : 12'(32'hB01 + k);
    return hi ? (a | 12'h080) : a;
  endfunction

  always_comb begin
    w_map     = 1'b0;
    w_inh_sel = 1'b0;
    w_lo_sel  = '0;
    w_hi_sel  = '0;
    w_evt_sel = '0;
    w_cur     = '0;
    if (csr_addr == 12'h320) begin
      w_map     = 1'b1;
      w_inh_sel = 1'b1;
      w_cur     = r_inh;
    end
    for (int k = 0; k < NTOT; k++) begin
      if (csr_addr == cnt_addr(k, 1'b0)) begin
        w_map       = 1'b1;
        w_lo_sel[k] = 1'b1;
        w_cur       = r_cnt[k][31:0];
      end
      if (csr_addr == cnt_addr(k, 1'b1)) begin
        w_map       = 1'b1;
        w_hi_sel[k] = 1'b1;
        w_cur       = 32'(r_cnt[k][CNT_WIDTH-1:32]);
      end
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      if (csr_addr == 12'(32'h323 + i)) begin
        w_map        = 1'b1;
        w_evt_sel[i] = 1'b1;
        w_cur        = 32'(r_evt[i]);
      end
    end
  end

  assign csr_hit   = csr_en & w_map;
  assign csr_rdata = csr_hit ? w_cur : 32'h0;
  assign w_wr      = csr_hit & csr_we & (csr_op != 2'd3);

  always_comb begin
    case (csr_op)
      2'd0:    w_wval = csr_wdata;
      2'd1:    w_wval = w_cur | csr_wdata;
      default: w_wval = w_cur & ~csr_wdata;
    endcase
  end

  // Increments use the inhibit value held before any write in this cycle.
  always_comb begin
    w_inc    = '0;
    w_wrap   = '0;
    w_inc[0] = ~r_inh[0];
    w_inc[1] = inst_retire & ~r_inh[2];
    for (int i = 0; i < NUM_CNT; i++) begin
      for (int e = 0; e < NUM_EVT; e++) begin
        if (r_evt[i] == EVT_SEL_W'(e + 1)) w_inc[2+i] = evt[e] & ~r_inh[3+i];
      end
      w_wrap[i] = w_inc[2+i] & (r_cnt[2+i] == CNT_MAX)
                & ~(w_wr & (w_lo_sel[2+i] | w_hi_sel[2+i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTOT; k++) r_cnt[k] <= '0;
      for (int i = 0; i < NUM_CNT; i++) r_evt[i] <= '0;
      r_inh <= '0;
      r_ovf <= '0;
    end else begin
      r_ovf <= w_wrap;
      for (int k = 0; k < NTOT; k++) begin
        if (w_wr && w_lo_sel[k])      r_cnt[k][31:0] <= w_wval;
        else if (w_wr && w_hi_sel[k]) r_cnt[k][CNT_WIDTH-1:32] <= w_wval[HI_W-1:0];
        else if (w_inc[k])            r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
      end
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_wr && w_evt_sel[i]) r_evt[i] <= w_wval[EVT_SEL_W-1:0];
      end
      if (w_wr && w_inh_sel) r_inh <= w_wval & INH_MASK;
    end
  end

  assign ovf = r_ovf;

endmodule

// File: tb/tb_ama_riscv_csr_hpm.sv
// Scoreboard bench for ama_riscv_csr_hpm: directed scenarios plus random CSR
// traffic, checked against an arithmetic model of the counter CSRs.
module tb_ama_riscv_csr_hpm;

  localparam int NC  = 4;
  localparam int CW  = 64;
  localparam int NE  = 8;
  localparam int ESW = $clog2(NE + 1);
  localparam longint unsigned CMASK = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);
  localparam longint unsigned HMASK = (CW == 64) ? 64'hFFFF_FFFF : ((64'd1 << (CW - 32)) - 64'd1);
  localparam logic [31:0] INH_IMPL = 32'h5 | 32'(((64'd1 << NC) - 64'd1) << 3);

  logic          clk;
  logic          rst;
  logic          csr_en;
  logic          csr_we;
  logic [11:0]   csr_addr;
  logic [1:0]    csr_op;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          csr_hit;
  logic          inst_retire;
  logic [NE-1:0] evt;
  logic [NC-1:0] ovf;

  ama_riscv_csr_hpm #(.NUM_CNT(NC), .CNT_WIDTH(CW), .NUM_EVT(NE)) dut (
    .clk(clk), .rst(rst), .csr_en(csr_en), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
    .inst_retire(inst_retire), .evt(evt), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]   addr;
    logic          hit;
    logic [31:0]   rdata;
    logic [NC-1:0] ovf;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Model state: cnt[0]=mcycle, cnt[1]=minstret, cnt[2+i]=mhpmcounter(3+i).
  longint unsigned m_cnt [NC+2];
  int unsigned     m_evt [NC];
  logic [31:0]     m_inh;
  logic [NC-1:0]   m_ovf;

  function automatic void model_reset();
    for (int c = 0; c < NC + 2; c++) m_cnt[c] = 0;
    for (int i = 0; i < NC; i++) m_evt[i] = 0;
    m_inh = '0;
    m_ovf = '0;
  endfunction

  // kind: 0 none, 1 counter low, 2 counter high, 3 event selector, 4 inhibit
  function automatic void decode(input logic [11:0] a, output int kind, output int idx);
    int off;
    kind = 0;
    idx  = 0;
    if (a == 12'h320) kind = 4;
    else if (a >= 12'h323 && int'(a) < 32'h323 + NC) begin
      kind = 3;
      idx  = int'(a) - 32'h323;
    end else if (a[11:8] == 4'hB) begin
      off = int'(a[6:0]);
      if (off == 0) idx = 0;
      else if (off == 2) idx = 1;
      else if (off >= 3 && off < 3 + NC) idx = off - 1;
      else idx = -1;
      if (idx >= 0) kind = a[7] ? 2 : 1;
      else idx = 0;
    end
  endfunction

  function automatic void model_read(input logic [11:0] a, output logic h, output logic [31:0] v);
    int kind, idx;
    decode(a, kind, idx);
    h = (kind != 0);
    case (kind)
      1: v = m_cnt[idx][31:0];
      2: v = 32'(m_cnt[idx] >> 32);
      3: v = m_evt[idx];
      4: v = m_inh;
      default: v = '0;
    endcase
  endfunction

  function automatic void model_step(input logic r, input logic en, input logic we,
                                     input logic [11:0] a, input logic [1:0] op,
                                     input logic [31:0] wd, input logic ret,
                                     input logic [NE-1:0] ev);
    int kind, idx;
    logic h, wr, go;
    logic [31:0] cur, wv;
    logic [NC-1:0] novf;
    if (r) begin
      model_reset();
      return;
    end
    model_read(a, h, cur);
    decode(a, kind, idx);
    wr = en && we && h && (op != 2'd3);
    wv = (op == 2'd0) ? wd : (op == 2'd1) ? (cur | wd) : (cur & ~wd);
    novf = '0;
    for (int c = 0; c < NC + 2; c++) begin
      if (c == 0) go = !m_inh[0];
      else if (c == 1) go = ret && !m_inh[2];
      else go = (m_evt[c-2] >= 1) && (m_evt[c-2] <= NE) && ev[m_evt[c-2]-1] && !m_inh[c+1];
      if (wr && (kind == 1 || kind == 2) && idx == c) go = 1'b0;
      if (go) begin
        if (c >= 2 && m_cnt[c] == CMASK) novf[c-2] = 1'b1;
        m_cnt[c] = (m_cnt[c] + 1) & CMASK;
      end
    end
    if (wr) begin
      case (kind)
        1: m_cnt[idx] = (m_cnt[idx] & ~64'hFFFF_FFFF) | {32'h0, wv};
        2: m_cnt[idx] = (m_cnt[idx] & 64'hFFFF_FFFF) | (({32'h0, wv} & HMASK) << 32);
        3: m_evt[idx] = wv % (32'd1 << ESW);
        4: m_inh = wv & INH_IMPL;
        default: ;
      endcase
    end
    m_ovf = novf;
  endfunction

  task automatic cyc(input logic en, input logic we, input logic [11:0] a, input logic [1:0] op,
                     input logic [31:0] wd, input logic ret, input logic [NE-1:0] ev,
                     input logic r = 1'b0);
    exp_t e;
    logic h;
    logic [31:0] v;
    rst = r; csr_en = en; csr_we = we; csr_addr = a; csr_op = op;
    csr_wdata = wd; inst_retire = ret; evt = ev;
    model_read(a, h, v);
    e.addr  = a;
    e.hit   = en && h;
    e.rdata = (en && h) ? v : 32'h0;
    e.ovf   = m_ovf;
    q.push_back(e);
    @(posedge clk);
    #1;
    model_step(r, en, we, a, op, wd, ret, ev);
  endtask

  task automatic rd(input logic [11:0] a, input logic ret = 1'b0, input logic [NE-1:0] ev = '0);
    cyc(1'b1, 1'b0, a, 2'd0, 32'h0, ret, ev);
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                    input logic ret = 1'b0, input logic [NE-1:0] ev = '0);
    cyc(1'b1, 1'b1, a, op, wd, ret, ev);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (csr_hit !== e.hit || csr_rdata !== e.rdata) begin
          n_fail++;
          $display("FAIL read addr=%h: got hit=%b rdata=%h, want hit=%b rdata=%h",
                   e.addr, csr_hit, csr_rdata, e.hit, e.rdata);
        end
        n_chk++;
        if (ovf !== e.ovf) begin
          n_fail++;
          $display("FAIL ovf addr=%h: got %b, want %b", e.addr, ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [11:0] addrs [24] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                              12'hB80, 12'hB82, 12'hB83, 12'hB84, 12'hB85, 12'hB86,
                              12'h320, 12'h323, 12'h324, 12'h325, 12'h326,
                              12'hB01, 12'hB07, 12'hB87, 12'h327, 12'h321, 12'h322, 12'hC00};

  initial begin
    logic [31:0] wd;
    logic [11:0] a;
    rst = 1'b1; csr_en = 0; csr_we = 0; csr_addr = '0; csr_op = '0;
    csr_wdata = '0; inst_retire = 0; evt = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, then mcycle counting from the first edge after release.
    cyc(1, 0, 12'hB00, 0, 0, 0, '0, 1'b1);
    for (int i = 0; i < 12; i++) rd(12'hB00);
    rd(12'hB80);
    rd(12'hC00);
    cyc(0, 0, 12'hB00, 0, 0, 0, '0);

    // Event selection on mhpmcounter3.
    wr(12'h323, 0, 32'h2);
    for (int i = 0; i < 5; i++) rd(12'hB03, 0, 8'h02);
    for (int i = 0; i < 3; i++) rd(12'hB03, 0, 8'h01);
    rd(12'hB03);
    wr(12'h323, 0, 32'h1F);
    rd(12'h323);
    for (int i = 0; i < 5; i++) rd(12'hB03, 0, 8'hFF);

    // Inhibit mcycle/minstret, then release with a clear op.
    wr(12'h320, 0, 32'h5, 1);
    for (int i = 0; i < 20; i++) rd((i % 2) ? 12'hB02 : 12'hB00, 1);
    wr(12'h320, 2, 32'h5, 1);
    for (int i = 0; i < 4; i++) rd((i % 2) ? 12'hB02 : 12'hB00, 1);
    wr(12'h320, 0, 32'hFFFF_FFFF);
    rd(12'h320);
    wr(12'h320, 0, 32'h0);

    // Full-width wrap of mhpmcounter3 with a single ovf pulse.
    wr(12'h323, 0, 32'h1);
    wr(12'hB83, 0, 32'hFFFF_FFFF);
    wr(12'hB03, 0, 32'hFFFF_FFFE);
    rd(12'hB83);
    for (int i = 0; i < 4; i++) rd(12'hB03, 0, 8'h01);
    rd(12'hB83, 0, 8'h01);
    rd(12'hB03);

    // Write beats same-cycle retire on minstret.
    wr(12'hB82, 0, 32'h0000_0007);
    wr(12'hB02, 0, 32'h100, 1);
    rd(12'hB02, 1);
    rd(12'hB02, 1);
    rd(12'hB82);

    // Set op on mhpmcounter4, then reset while counting.
    wr(12'h324, 0, 32'h3);
    wr(12'hB04, 0, 32'h0F);
    wr(12'hB04, 1, 32'hF0);
    rd(12'hB04);
    for (int i = 0; i < 3; i++) rd(12'hB04, 1, 8'h04);
    cyc(1, 0, 12'hB04, 0, 0, 1, 8'h04, 1'b1);
    rd(12'hB04, 0);
    rd(12'h324);
    rd(12'hB02);

    // Reset on the wrapping edge drops the pending ovf.
    wr(12'h323, 0, 32'h1);
    wr(12'hB83, 0, 32'hFFFF_FFFF);
    wr(12'hB03, 0, 32'hFFFF_FFFF);
    cyc(1, 0, 12'hB03, 0, 0, 0, 8'h01, 1'b1);
    rd(12'hB03);
    rd(12'hB03);

    // Random CSR traffic.
    for (int n = 0; n < 1800; n++) begin
      case ($urandom_range(0, 3))
        0: wd = 32'hFFFF_FFFF;
        1: wd = 32'hFFFF_FFFE;
        default: wd = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 12'($urandom);
      else a = addrs[$urandom_range(0, 23)];
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), a,
          2'($urandom_range(0, 3)), wd, 1'($urandom), 8'($urandom | $urandom),
          ($urandom_range(0, 299) == 0));
    end

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
